// File: rtl/cassette_pkg.sv
// Shared types, timing defaults and the half-cycle classifier for the Electron cassette
// receive path. Defaults assume a 16 MHz clk (short half ~3333 cycles, long half ~6667).
package cassette_pkg;

  typedef enum logic [1:0] {
    HcNone,
    HcShort,
    HcLong,
    HcGlitch
  } half_class_e;

  typedef enum logic [1:0] {
    FrIdle,
    FrData,
    FrStop
  } framer_state_e;

  localparam logic [15:0] DefShortMin = 16'd1600;
  localparam logic [15:0] DefThresh   = 16'd5000;
  localparam logic [15:0] DefLongMax  = 16'd10000;
  localparam logic [4:0]  DefHtBits   = 5'd8;

  localparam logic [15:0] CntMax = 16'hFFFF;

  function automatic half_class_e classify_half(logic [15:0] width, logic [15:0] short_min,
                                                logic [15:0] thresh);
    half_class_e cls;
    if (width < short_min) begin
      cls = HcGlitch;
    end else if (width < thresh) begin
      cls = HcShort;
    end else begin
      cls = HcLong;
    end
    return cls;
  endfunction

endpackage

// File: rtl/cas_halfcycle_meter.sv
// Tape input front end: synchronises cas_in, times each half-cycle between edges, classifies
// it, and flags silence when no edge arrives within LONG_MAX clocks.
module cas_halfcycle_meter
  import cassette_pkg::*;
#(
  parameter logic [15:0] SHORT_MIN = DefShortMin,
  parameter logic [15:0] THRESH    = DefThresh,
  parameter logic [15:0] LONG_MAX  = DefLongMax
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        cas_in,
  output logic        hc_valid,
  output half_class_e hc_class,
  output logic        timeout
);

  logic        sync1_q, sync2_q, level_q;
  logic [15:0] cnt_q;
  // Clear after reset, en low or silence: the next edge only starts a new measurement.
  logic        armed_q;
  logic        edge_det;

  assign edge_det = sync2_q ^ level_q;
  // An edge reloads the counter, so it always wins over a coincident timeout.
  assign timeout  = en && !edge_det && (cnt_q == LONG_MAX);
  assign hc_valid = en && edge_det && armed_q;
  assign hc_class = classify_half(cnt_q, SHORT_MIN, THRESH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= 16'd0;
      armed_q <= 1'b0;
    end else begin
      sync1_q <= cas_in;
      sync2_q <= sync1_q;
      level_q <= sync2_q;
      if (!en) begin
        cnt_q   <= 16'd0;
        armed_q <= 1'b0;
      end else if (edge_det) begin
        cnt_q   <= 16'd1;
        armed_q <= 1'b1;
      end else begin
        if (cnt_q != CntMax) begin
          cnt_q <= cnt_q + 16'd1;
        end
        if (timeout) begin
          armed_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/cassette_decoder.sv
// Cassette receive decoder: slices classified half-cycles into bits (4 short = 1, 2 long = 0)
// and frames start + 8 LSB-first data + stop into bytes, with a high-tone carrier flag.
module cassette_decoder
  import cassette_pkg::*;
#(
  parameter logic [15:0] SHORT_MIN = DefShortMin,
  parameter logic [15:0] THRESH    = DefThresh,
  parameter logic [15:0] LONG_MAX  = DefLongMax,
  parameter logic [4:0]  HT_BITS   = DefHtBits
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       cas_in,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       framing_err,
  output logic       high_tone
);

  logic        hc_valid;
  half_class_e hc_class;
  logic        timeout;

  cas_halfcycle_meter #(
    .SHORT_MIN(SHORT_MIN),
    .THRESH   (THRESH),
    .LONG_MAX (LONG_MAX)
  ) u_meter (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .cas_in  (cas_in),
    .hc_valid(hc_valid),
    .hc_class(hc_class),
    .timeout (timeout)
  );

  // Slicer
  half_class_e slc_cls_q, slc_cls_d;
  logic [1:0]  slc_cnt_q, slc_cnt_d;
  logic [2:0]  run_len;
  logic        bit_vld;
  logic        bit_val;

  always_comb begin
    slc_cls_d = slc_cls_q;
    slc_cnt_d = slc_cnt_q;
    run_len   = 3'd1;
    bit_vld   = 1'b0;
    bit_val   = 1'b0;
    if (!en || timeout) begin
      slc_cls_d = HcNone;
      slc_cnt_d = 2'd0;
    end else if (hc_valid) begin
      if (hc_class == HcGlitch) begin
        slc_cls_d = HcNone;
        slc_cnt_d = 2'd0;
      end else begin
        if (hc_class == slc_cls_q) begin
          run_len = {1'b0, slc_cnt_q} + 3'd1;
        end
        if ((hc_class == HcShort) && (run_len == 3'd4)) begin
          bit_vld   = 1'b1;
          bit_val   = 1'b1;
          slc_cls_d = HcNone;
          slc_cnt_d = 2'd0;
        end else if ((hc_class == HcLong) && (run_len == 3'd2)) begin
          bit_vld   = 1'b1;
          bit_val   = 1'b0;
          slc_cls_d = HcNone;
          slc_cnt_d = 2'd0;
        end else begin
          slc_cls_d = hc_class;
          slc_cnt_d = run_len[1:0];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slc_cls_q <= HcNone;
      slc_cnt_q <= 2'd0;
    end else begin
      slc_cls_q <= slc_cls_d;
      slc_cnt_q <= slc_cnt_d;
    end
  end

  // Framer
  framer_state_e fr_state_q;
  logic [7:0]    shift_q;
  logic [2:0]    bit_idx_q;
  logic [4:0]    ones_q;
  logic [4:0]    ones_inc;

  assign ones_inc = (ones_q >= HT_BITS) ? HT_BITS : ones_q + 5'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fr_state_q  <= FrIdle;
      shift_q     <= 8'h00;
      bit_idx_q   <= 3'd0;
      ones_q      <= 5'd0;
      data_out    <= 8'h00;
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      high_tone   <= 1'b0;
    end else begin
      data_valid  <= 1'b0;
      framing_err <= 1'b0;
      if (!en || timeout) begin
        // Silence or motor off abandons any partial byte without reporting an error.
        fr_state_q <= FrIdle;
        ones_q     <= 5'd0;
        high_tone  <= 1'b0;
      end else if (bit_vld) begin
        unique case (fr_state_q)
          FrIdle: begin
            if (bit_val) begin
              ones_q    <= ones_inc;
              high_tone <= (ones_inc >= HT_BITS);
            end else begin
              fr_state_q <= FrData;
              shift_q    <= 8'h00;
              bit_idx_q  <= 3'd0;
              ones_q     <= 5'd0;
              high_tone  <= 1'b0;
            end
          end
          FrData: begin
            shift_q   <= {bit_val, shift_q[7:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == 3'd7) begin
              fr_state_q <= FrStop;
            end
          end
          FrStop: begin
            if (bit_val) begin
              data_out   <= shift_q;
              data_valid <= 1'b1;
            end else begin
              framing_err <= 1'b1;
            end
            fr_state_q <= FrIdle;
            ones_q     <= 5'd0;
          end
          default: begin
            fr_state_q <= FrIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cassette_decoder.sv
// Randomised bench for cassette_decoder: drives half-cycle widths and checks against an
// event-level model of the tape format (bits from half runs, bytes from framed bits).
module tb_cassette_decoder;

  localparam logic [15:0] SMIN = 16'd16;
  localparam logic [15:0] THR  = 16'd48;
  localparam logic [15:0] LMAX = 16'd120;
  localparam logic [4:0]  HT   = 5'd8;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       cas_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       framing_err;
  logic       high_tone;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  cassette_decoder #(
    .SHORT_MIN(SMIN),
    .THRESH   (THR),
    .LONG_MAX (LMAX),
    .HT_BITS  (HT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .cas_in     (cas_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .framing_err(framing_err),
    .high_tone  (high_tone)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: tape format rules applied to a stream of half widths.
  bit   m_armed;
  int   m_cls;   // 0 none, 1 short, 2 long
  int   m_cnt;
  int   m_mode;  // 0 idle, 1 data, 2 stop
  bit   m_bits[$];
  int   m_ones;
  bit   m_ht;
  int   m_dout;
  int   exp_q[$];  // byte value for a good frame, -1 for a framing error
  int   probe_ht   = -1;
  int   probe_dout = -1;

  task automatic model_quiet();
    m_armed = 1'b0;
    m_cls   = 0;
    m_cnt   = 0;
    m_mode  = 0;
    m_ht    = 1'b0;
    m_ones  = 0;
  endtask

  task automatic model_reset();
    model_quiet();
    m_dout = 0;
  endtask

  task automatic model_bit(input bit b);
    int v;
    v = 0;
    if (m_mode == 0) begin
      if (b) begin
        if (m_ones < int'(HT)) m_ones++;
        m_ht = (m_ones >= int'(HT));
      end else begin
        m_mode = 1;
        m_bits.delete();
        m_ht   = 1'b0;
        m_ones = 0;
      end
    end else if (m_mode == 1) begin
      m_bits.push_back(b);
      if (m_bits.size() == 8) m_mode = 2;
    end else begin
      if (b) begin
        foreach (m_bits[i]) v = v | (int'(m_bits[i]) << i);
        m_dout = v;
        exp_q.push_back(v);
      end else begin
        exp_q.push_back(-1);
      end
      m_mode = 0;
      m_ones = 0;
    end
  endtask

  task automatic model_edge(input int w);
    int cls;
    if (w > int'(LMAX)) model_quiet();
    if (!m_armed) begin
      m_armed = 1'b1;
    end else if (w < int'(SMIN)) begin
      m_cls = 0;
      m_cnt = 0;
    end else begin
      cls = (w < int'(THR)) ? 1 : 2;
      if (cls == m_cls) m_cnt++;
      else begin
        m_cls = cls;
        m_cnt = 1;
      end
      if (cls == 1 && m_cnt == 4) begin
        m_cls = 0;
        m_cnt = 0;
        model_bit(1'b1);
      end else if (cls == 2 && m_cnt == 2) begin
        m_cls = 0;
        m_cnt = 0;
        model_bit(1'b0);
      end
    end
  endtask

  // Hold the line for w clocks, then toggle; checks state left by the previous edge.
  task automatic half(input int w);
    for (int i = 0; i < w; i++) begin
      @(negedge clk);
      if (i == 4) begin
        check("high_tone", 32'(high_tone), 32'(m_ht));
        check("data_out_held", 32'(data_out), m_dout);
        if (probe_ht >= 0) begin
          check("high_tone_expected", 32'(high_tone), probe_ht);
          probe_ht = -1;
        end
        if (probe_dout >= 0) begin
          check("data_out_expected", 32'(data_out), probe_dout);
          probe_dout = -1;
        end
      end
    end
    cas_in = ~cas_in;
    model_edge(w);
  endtask

  task automatic send_bit(input bit b);
    if (b) repeat (4) half(int'($urandom_range(20, 44)));
    else repeat (2) half(int'($urandom_range(52, 110)));
  endtask

  task automatic preamble(input int n);
    repeat (n) send_bit(1'b1);
  endtask

  task automatic send_body(input logic [7:0] b, input bit stop);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop);
    send_bit(1'b0);
    send_body(b, stop);
  endtask

  task automatic en_gap();
    repeat (10) @(negedge clk);
    en = 1'b0;
    model_quiet();
    for (int k = 0; k < 6; k++) begin
      repeat (30) @(negedge clk);
      cas_in = ~cas_in;
    end
    repeat (10) @(negedge clk);
    check("en_low_high_tone", 32'(high_tone), 32'd0);
    check("en_low_data_out", 32'(data_out), m_dout);
    en = 1'b1;
    half(30);
  endtask

  // Pulse scoreboard: every pulse must match the next model event, one cycle each.
  always @(negedge clk) begin
    int e;
    if (!reset && (data_valid || framing_err)) begin
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'({data_valid, framing_err}), 32'd0);
      end else begin
        e = exp_q.pop_front();
        if (e < 0) begin
          check("framing_err_pulse", 32'({data_valid, framing_err}), 32'b01);
        end else begin
          check("data_valid_pulse", 32'({data_valid, framing_err}), 32'b10);
          check("data_valid_byte", 32'(data_out), e);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] rb;
    reset  = 1'b1;
    en     = 1'b0;
    cas_in = 1'b0;
    model_reset();
    repeat (4) @(negedge clk);
    check("reset_data_out", 32'(data_out), 32'h00);
    check("reset_data_valid", 32'(data_valid), 32'd0);
    check("reset_framing_err", 32'(framing_err), 32'd0);
    check("reset_high_tone", 32'(high_tone), 32'd0);
    reset = 1'b0;
    en    = 1'b1;
    half(30);

    // High tone then a good byte.
    preamble(7);
    probe_ht = 0;
    preamble(1);
    probe_ht = 1;
    preamble(12);
    send_bit(1'b0);
    probe_ht = 0;
    send_body(8'hA5, 1'b1);
    probe_dout = 8'hA5;
    preamble(2);

    // Bad stop bit keeps previous data.
    send_frame(8'h3C, 1'b0);
    probe_dout = 8'hA5;
    preamble(2);

    // Silence mid-byte, then a clean byte.
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    half(200);
    send_frame(8'h3C, 1'b1);
    probe_dout = 8'h3C;
    preamble(2);

    // Glitch pair inside a one bit.
    preamble(2);
    half(20);
    half(5);
    half(10);
    preamble(3);
    send_frame(8'h81, 1'b1);
    probe_dout = 8'h81;
    preamble(2);

    // Width boundaries: SHORT_MIN and THRESH-1 are short, THRESH and LONG_MAX are long.
    half(int'(SMIN));
    half(int'(SMIN));
    half(int'(THR) - 1);
    half(int'(SMIN));
    half(int'(THR));
    half(int'(LMAX));
    send_body(8'h96, 1'b1);
    probe_dout = 8'h96;
    preamble(2);
    half(int'(SMIN) - 1);
    half(int'(LMAX) + 1);
    preamble(2);

    // Asynchronous reset in data bit 5.
    send_bit(1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'(8'hC3 >> i));
    half(30);
    repeat (7) @(negedge clk);
    #2 reset = 1'b1;
    cas_in = 1'b0;
    model_reset();
    #1;
    check("async_reset_data_out", 32'(data_out), 32'h00);
    check("async_reset_high_tone", 32'(high_tone), 32'd0);
    check("async_reset_pulses", 32'({data_valid, framing_err}), 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    half(30);
    send_frame(8'h5A, 1'b1);
    probe_dout = 8'h5A;
    preamble(2);

    // Enable dropped mid-byte.
    preamble(10);
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1);
    en_gap();
    send_frame(8'hFF, 1'b1);
    probe_dout = 8'hFF;
    preamble(2);

    // Random mix of frames, glitches, silences and enable gaps.
    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: begin
          rb = 8'($urandom_range(0, 255));
          send_frame(rb, $urandom_range(0, 4) != 0);
        end
        6: preamble(int'($urandom_range(1, 10)));
        7: half(int'($urandom_range(3, 12)));
        8: half(int'($urandom_range(130, 300)));
        default: en_gap();
      endcase
    end
    preamble(3);
    repeat (20) @(negedge clk);
    check("pending_events", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
